// File: rtl/fifo_wptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_wptr_ctrl_if
// Purpose : groups the write-side control signals of an asynchronous FIFO's
//           write-pointer controller.
// Signals :
//   winc         write request (master -> controller)
//   wclr_ovf     clear sticky overflow flag (master -> controller)
//   wq2_rptr     Gray read pointer, already synchronized into the write clock
//   waddr        RAM write address (controller -> master)
//   wptr         registered Gray write pointer for the read-side synchronizer
//   wfull        registered full flag
//   walmost_full registered almost-full flag
//   wlevel       registered fill level, 0..DEPTH
//   woverflow    sticky flag, set by a write attempted while full
// Modports: master drives requests and observes status; slave is the
//           controller itself.
// -----------------------------------------------------------------------------
interface fifo_wptr_ctrl_if #(
    parameter int ADDRESS_WIDTH = 3
);
    logic                     winc;
    logic                     wclr_ovf;
    logic [ADDRESS_WIDTH:0]   wq2_rptr;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [ADDRESS_WIDTH:0]   wptr;
    logic                     wfull;
    logic                     walmost_full;
    logic [ADDRESS_WIDTH:0]   wlevel;
    logic                     woverflow;

    modport master (
        output winc,
        output wclr_ovf,
        output wq2_rptr,
        input  waddr,
        input  wptr,
        input  wfull,
        input  walmost_full,
        input  wlevel,
        input  woverflow
    );

    modport slave (
        input  winc,
        input  wclr_ovf,
        input  wq2_rptr,
        output waddr,
        output wptr,
        output wfull,
        output walmost_full,
        output wlevel,
        output woverflow
    );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wptr_ctrl
// Purpose : write-domain pointer and flag logic of an asynchronous FIFO.
//           Keeps a binary write pointer, publishes its Gray code from a flop,
//           and derives registered full / almost-full / level flags from the
//           synchronized Gray read pointer. Tracks a sticky overflow flag.
// Ports   :
//   wclk  write-domain clock, all state updates on its rising edge
//   wrst  synchronous active-high reset
//   bus   fifo_wptr_ctrl_if.slave (winc, wclr_ovf, wq2_rptr in;
//         waddr, wptr, wfull, walmost_full, wlevel, woverflow out)
// Parameters:
//   ADDRESS_WIDTH  RAM address bits (2..16); DEPTH = 2**ADDRESS_WIDTH
//   AFULL_THRESH   free-slot count at or below which almost-full asserts
// -----------------------------------------------------------------------------
module fifo_wptr_ctrl #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int AFULL_THRESH  = 2
) (
    input  logic               wclk,
    input  logic               wrst,
    fifo_wptr_ctrl_if.slave    bus
);
    localparam int AW = ADDRESS_WIDTH;

    // One extra bit over the pointer width so DEPTH - level never aliases.
    localparam logic [AW+1:0] DEPTH_EXT  = {2'b01, {AW{1'b0}}};
    localparam logic [AW+1:0] THRESH_EXT = (AW+2)'(AFULL_THRESH);

    logic [AW:0] wbin_q,  wbin_d;
    logic [AW:0] wptr_q,  wptr_d;
    logic [AW:0] wlevel_q, wlevel_d;
    logic        wfull_q,  wfull_d;
    logic        walmost_full_q, walmost_full_d;
    logic        woverflow_q,    woverflow_d;

    logic        accept;
    logic [AW:0] rbin;
    logic [AW:0] full_cmp;
    logic [AW+1:0] free_ext;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi <= AW; gi++) begin : g_rbin
            assign rbin[gi] = ^bus.wq2_rptr[AW:gi];
        end
    endgenerate

    // The write pointer is exactly DEPTH ahead of the read pointer when its
    // Gray code matches the read Gray code with the two MSBs inverted.
    assign full_cmp = {~bus.wq2_rptr[AW:AW-1], bus.wq2_rptr[AW-2:0]};

    always_comb begin
        accept         = bus.winc & ~wfull_q;
        wbin_d         = wbin_q + {{AW{1'b0}}, accept};
        wptr_d         = wbin_d ^ (wbin_d >> 1);
        wfull_d        = (wptr_d == full_cmp);
        wlevel_d       = wbin_d - rbin;
        free_ext       = DEPTH_EXT - {1'b0, wlevel_d};
        walmost_full_d = (free_ext <= THRESH_EXT);

        // A rejected write beats a simultaneous clear.
        woverflow_d = woverflow_q;
        if (bus.winc && wfull_q) begin
            woverflow_d = 1'b1;
        end else if (bus.wclr_ovf) begin
            woverflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign bus.waddr        = wbin_q[AW-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.woverflow    = woverflow_q;
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_ctrl
// Self-checking bench for fifo_wptr_ctrl (ADDRESS_WIDTH=3, AFULL_THRESH=2).
// A directed vector table, hand sequences for wrap and mid-operation reset,
// and randomized traffic against a count-based reference model.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_ctrl;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int THR   = 2;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    always #5 wclk = ~wclk;

    fifo_wptr_ctrl_if #(.ADDRESS_WIDTH(AW)) bus ();

    fifo_wptr_ctrl #(
        .ADDRESS_WIDTH(AW),
        .AFULL_THRESH (THR)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: total accepted writes, plus expected outputs.
    int m_wr = 0;
    int e_waddr, e_wptr, e_level;
    bit e_full, e_afull, e_ovf;

    function automatic int gray4(input int v);
        logic [3:0] b;
        b = v[3:0];
        return int'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one cycle of inputs, advance the model, wait past the edge.
    task automatic step(input bit rst, input bit inc, input bit clr, input int rd);
        wrst         = rst;
        bus.winc     = inc;
        bus.wclr_ovf = clr;
        bus.wq2_rptr = 4'(gray4(rd));
        if (rst) begin
            m_wr = 0; e_waddr = 0; e_wptr = 0; e_level = 0;
            e_full = 0; e_afull = 0; e_ovf = 0;
        end else begin
            if (inc && e_full) e_ovf = 1;
            else if (clr)      e_ovf = 0;
            if (inc && !e_full) m_wr++;
            e_level = (((m_wr - rd) % 16) + 16) % 16;
            e_full  = (e_level == DEPTH);
            e_afull = ((DEPTH - e_level) <= THR);
            e_wptr  = gray4(m_wr);
            e_waddr = m_wr % DEPTH;
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".waddr"},  int'(bus.waddr),        e_waddr);
        chk({tag, ".wptr"},   int'(bus.wptr),         e_wptr);
        chk({tag, ".wlevel"}, int'(bus.wlevel),       e_level);
        chk({tag, ".wfull"},  int'(bus.wfull),        int'(e_full));
        chk({tag, ".wafull"}, int'(bus.walmost_full), int'(e_afull));
        chk({tag, ".wovf"},   int'(bus.woverflow),    int'(e_ovf));
    endtask

    typedef struct {
        bit rst; bit inc; bit clr; int rd;
        int level; bit full; bit afull; bit ovf; int wptr; int waddr;
    } vec_t;

    vec_t tbl [17];

    initial begin
        bus.winc = 0; bus.wclr_ovf = 0; bus.wq2_rptr = '0;

        //          rst inc clr rd  lvl full afl ovf wptr waddr
        tbl[0]  = '{1, 0, 0, 0,   0, 0, 0, 0,  0, 0};
        tbl[1]  = '{0, 1, 0, 0,   1, 0, 0, 0,  1, 1};
        tbl[2]  = '{0, 1, 0, 0,   2, 0, 0, 0,  3, 2};
        tbl[3]  = '{0, 1, 0, 0,   3, 0, 0, 0,  2, 3};
        tbl[4]  = '{0, 1, 0, 0,   4, 0, 0, 0,  6, 4};
        tbl[5]  = '{0, 1, 0, 0,   5, 0, 0, 0,  7, 5};
        tbl[6]  = '{0, 1, 0, 0,   6, 0, 1, 0,  5, 6};
        tbl[7]  = '{0, 1, 0, 0,   7, 0, 1, 0,  4, 7};
        tbl[8]  = '{0, 1, 0, 0,   8, 1, 1, 0, 12, 0};
        tbl[9]  = '{0, 1, 0, 0,   8, 1, 1, 1, 12, 0};  // write while full
        tbl[10] = '{0, 0, 1, 0,   8, 1, 1, 0, 12, 0};  // clear
        tbl[11] = '{0, 1, 1, 0,   8, 1, 1, 1, 12, 0};  // set beats clear
        tbl[12] = '{0, 0, 1, 0,   8, 1, 1, 0, 12, 0};
        tbl[13] = '{0, 0, 0, 1,   7, 0, 1, 0, 12, 0};  // release
        tbl[14] = '{0, 1, 0, 1,   8, 1, 1, 0, 13, 1};
        tbl[15] = '{0, 1, 0, 2,   7, 0, 1, 1, 13, 1};  // write+read while full
        tbl[16] = '{0, 0, 1, 2,   7, 0, 1, 0, 13, 1};

        @(negedge wclk);
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].inc, tbl[i].clr, tbl[i].rd);
            chk($sformatf("vec%0d.waddr", i),  int'(bus.waddr),        tbl[i].waddr);
            chk($sformatf("vec%0d.wptr", i),   int'(bus.wptr),         tbl[i].wptr);
            chk($sformatf("vec%0d.wlevel", i), int'(bus.wlevel),       tbl[i].level);
            chk($sformatf("vec%0d.wfull", i),  int'(bus.wfull),        int'(tbl[i].full));
            chk($sformatf("vec%0d.wafull", i), int'(bus.walmost_full), int'(tbl[i].afull));
            chk($sformatf("vec%0d.wovf", i),   int'(bus.woverflow),    int'(tbl[i].ovf));
            $display("vec %0d: winc=%0b clr=%0b rd=%0d -> wptr=%b lvl=%0d full=%0b afull=%0b ovf=%0b",
                     i, tbl[i].inc, tbl[i].clr, tbl[i].rd, bus.wptr, bus.wlevel,
                     bus.wfull, bus.walmost_full, bus.woverflow);
        end

        // Wrap: 20 writes with the read pointer two behind.
        begin
            logic [3:0] prev;
            bit seen8, seen0;
            seen8 = 0; seen0 = 0;
            step(1, 0, 0, 0);
            prev = bus.wptr;
            for (int k = 0; k < 20; k++) begin
                step(0, 1, 0, (k >= 2) ? k - 2 : 0);
                check_model("wrap");
                chk("wrap.gray_step", $countones(prev ^ bus.wptr), 1);
                chk("wrap.never_full", int'(bus.wfull), 0);
                if (bus.wptr == 4'b1000) seen8 = 1;
                if (bus.wptr == 4'b0000 && seen8) seen0 = 1;
                $display("wrap %0d: wptr=%b lvl=%0d", k, bus.wptr, bus.wlevel);
                prev = bus.wptr;
            end
            chk("wrap.saw_1000", int'(seen8), 1);
            chk("wrap.saw_0000", int'(seen0), 1);
        end

        // Mid-operation reset at level 5 with a write pending.
        step(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
        chk("mrst.level5", int'(bus.wlevel), 5);
        step(1, 1, 0, 0);
        check_model("mrst");
        chk("mrst.waddr0", int'(bus.waddr), 0);
        chk("mrst.wptr0",  int'(bus.wptr), 0);
        step(0, 0, 0, 0);
        chk("mrst.no_write", int'(bus.waddr), 0);
        step(0, 1, 0, 0);
        chk("mrst.resume", int'(bus.waddr), 1);
        $display("mid-reset: resumed waddr=%0d lvl=%0d", bus.waddr, bus.wlevel);

        // Randomized traffic against the count model.
        begin
            int rd;
            bit r_rst, r_inc, r_clr;
            step(1, 0, 0, 0);
            rd = 0;
            for (int i = 0; i < 400; i++) begin
                r_rst = ($urandom_range(0, 49) == 0);
                r_inc = ($urandom_range(0, 3) != 0);
                r_clr = ($urandom_range(0, 7) == 0);
                if (r_rst) rd = 0;
                else if ($urandom_range(0, 2) == 0 && rd < m_wr) rd++;
                step(r_rst, r_inc, r_clr, rd);
                check_model($sformatf("rand%0d", i));
                $display("rand %0d: rst=%0b inc=%0b clr=%0b rd=%0d -> wptr=%b lvl=%0d full=%0b ovf=%0b",
                         i, r_rst, r_inc, r_clr, rd, bus.wptr, bus.wlevel, bus.wfull, bus.woverflow);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_ctrl.md
FIFO_WPTR_CTRL -- requirements
Module: fifo_wptr_ctrl

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 3, meaning the FIFO address bits; legal range is 2 to 16.
REQ-002 SHALL provide parameter AFULL_THRESH, default 2, meaning the free-slot count at or below which almost-full asserts; legal range is 0 to 2^ADDRESS_WIDTH-1.
REQ-003 SHALL define DEPTH = 2^ADDRESS_WIDTH, and pointers SHALL be ADDRESS_WIDTH+1 bits wide.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-006 SHALL have wrst  input  1  synchronous active-high reset.
REQ-007 SHALL have winc  input  1  write request.
REQ-008 SHALL have wclr_ovf  input  1  clears the sticky overflow flag.
REQ-009 SHALL have wq2_rptr  input  ADDRESS_WIDTH+1  Gray read pointer, already synchronized into wclk.
REQ-010 SHALL have waddr  output  ADDRESS_WIDTH  RAM write address.
REQ-011 SHALL have wptr  output  ADDRESS_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-012 SHALL have wfull  output  1  registered full flag.
REQ-013 SHALL have walmost_full  output  1  registered almost-full flag.
REQ-014 SHALL have wlevel  output  ADDRESS_WIDTH+1  registered fill level, range 0..DEPTH.
REQ-015 SHALL have woverflow  output  1  sticky flag for a write attempted while full.

Function
REQ-016 SHALL hold an internal binary pointer wbin of ADDRESS_WIDTH+1 bits; a write is accepted when winc=1 and wfull=0.
REQ-017 SHALL compute wbin_next = wbin+1 (modulo 2^(ADDRESS_WIDTH+1)) on an accepted write, else wbin_next = wbin.
REQ-018 SHALL register wbin <= wbin_next and wptr <= wbin_next ^ (wbin_next >> 1) on every edge, so wptr is the Gray code of wbin at all times; wptr SHALL come directly from a flop with no combinational output logic.
REQ-019 SHALL drive waddr = wbin[ADDRESS_WIDTH-1:0] combinationally from the register.
REQ-020 SHALL register wfull <= (gray(wbin_next) == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}), generic for any ADDRESS_WIDTH with no lookup tables.
REQ-021 SHALL convert wq2_rptr combinationally to binary rbin by prefix XOR from the MSB down.
REQ-022 SHALL register wlevel <= wbin_next - rbin (modulo 2^(ADDRESS_WIDTH+1)).
REQ-023 SHALL register walmost_full <= ((DEPTH - level_next) <= AFULL_THRESH), where level_next is the value loaded into wlevel.
REQ-024 SHALL have a latency of 1 cycle: a write accepted in cycle N shows in waddr, wptr, wlevel, wfull and walmost_full from cycle N+1.
REQ-025 SHALL reflect a change on wq2_rptr in wfull, wlevel and walmost_full one edge later.
REQ-026 SHALL, on a write attempted while full, leave wbin and wptr unchanged and set woverflow at the next edge.
REQ-027 SHALL clear woverflow at the next edge when wclr_ovf=1; if a set and a clear occur in the same cycle, set SHALL win.
REQ-028 SHALL wrap pointer wrap-around silently, with every wptr change differing by exactly one bit.
REQ-029 SHALL handle a simultaneous write and read-pointer advance while full as follows: the write is rejected (wfull=1 that cycle), and wfull deasserts at the next edge.

Reset
REQ-030 SHALL, when wrst=1 at an edge, set wbin, wptr, wlevel, wfull, walmost_full and woverflow to 0, so that waddr=0; winc and wclr_ovf SHALL be ignored in that cycle.
REQ-031 SHALL override all other behaviour with reset mid-operation; normal operation SHALL resume on the first edge with wrst=0.

Verification
REQ-032 SHALL cover reset (ADDRESS_WIDTH=3): wrst=1 for 1 cycle -> all outputs are 0.
REQ-033 SHALL cover fill: wq2_rptr=0000 and 8 consecutive winc -> walmost_full=1 after the 6th write (wlevel=6); after the 8th write, wfull=1, wptr=1100, wlevel=8, waddr=0.
REQ-034 SHALL cover overflow: winc while full -> wptr stays 1100 and woverflow=1 next cycle; then wclr_ovf=1 -> woverflow=0.
REQ-035 SHALL cover release: while full, drive wq2_rptr=0001 -> wfull=0 and wlevel=7 next cycle, with walmost_full still 1.
REQ-036 SHALL cover wrap: 20 writes with wq2_rptr tracking 2 behind -> wptr passes 1000 and then 0000, with a single-bit Gray change checked every cycle and wfull never set.
REQ-037 SHALL cover mid-operation reset: assert wrst at wlevel=5 with winc=1 -> all outputs 0 next cycle, and no write is accepted.
